// File: rtl/wb_result_stage.sv
// rtl/wb_result_stage.sv - MEM/WB boundary register with NSRC-way writeback result select
// Also provides qualified register-file write enable, stall/flush control and a retired-instruction counter.
module wb_result_stage #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = 2,
  parameter int CNTW  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  StallW,
  input  logic                  FlushW,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic [4:0]            RdM,
  input  logic [SELW-1:0]       ResultSrcM,
  input  logic [NSRC*WIDTH-1:0] SrcDataM,
  output logic [WIDTH-1:0]      ResultW,
  output logic [4:0]            RdW,
  output logic                  RegWriteW,
  output logic                  ValidW,
  output logic [CNTW-1:0]       InstRetW
);

  logic [WIDTH-1:0] sel_data;
  logic             we_next;

  // Selects beyond the populated sources read as zero rather than aliasing.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(ResultSrcM) == k) sel_data = SrcDataM[k*WIDTH +: WIDTH];
    end
  end

  // Writes to x0 are dropped here so the register file never sees them.
  assign we_next = RegWriteM & ValidM & (RdM != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ResultW   <= '0;
      RdW       <= '0;
      RegWriteW <= 1'b0;
      ValidW    <= 1'b0;
      InstRetW  <= '0;
    end else if (FlushW) begin
      ResultW   <= '0;
      RdW       <= '0;
      RegWriteW <= 1'b0;
      ValidW    <= 1'b0;
    end else if (!StallW) begin
      ResultW   <= sel_data;
      RdW       <= RdM;
      RegWriteW <= we_next;
      ValidW    <= ValidM;
      if (ValidM) InstRetW <= InstRetW + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_wb_result_stage.sv
// tb/tb_wb_result_stage.sv - self-checking bench for wb_result_stage
// Three builds (default, CNTW=4, NSRC=3) share stimulus and are checked against one reference model.
module tb_wb_result_stage;

  logic         clk;
  logic         reset;
  logic         StallW, FlushW, ValidM, RegWriteM;
  logic [4:0]   RdM;
  logic [1:0]   ResultSrcM;
  logic [127:0] SrcDataM;

  logic [31:0] ResultW, ResultW_c4, ResultW_n3;
  logic [4:0]  RdW, RdW_c4, RdW_n3;
  logic        RegWriteW, RegWriteW_c4, RegWriteW_n3;
  logic        ValidW, ValidW_c4, ValidW_n3;
  logic [31:0] InstRetW, InstRetW_n3;
  logic [3:0]  InstRetW_c4;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] srcs [4];
  logic [31:0] m_res, m_res3;
  logic [4:0]  m_rd;
  logic        m_we, m_val;
  logic [31:0] m_cnt;

  wb_result_stage dut (
    .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .SrcDataM(SrcDataM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .ValidW(ValidW), .InstRetW(InstRetW)
  );

  wb_result_stage #(.CNTW(4)) dut_c4 (
    .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .SrcDataM(SrcDataM),
    .ResultW(ResultW_c4), .RdW(RdW_c4), .RegWriteW(RegWriteW_c4), .ValidW(ValidW_c4),
    .InstRetW(InstRetW_c4)
  );

  wb_result_stage #(.NSRC(3)) dut_n3 (
    .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .SrcDataM(SrcDataM[95:0]),
    .ResultW(ResultW_n3), .RdW(RdW_n3), .RegWriteW(RegWriteW_n3), .ValidW(ValidW_n3),
    .InstRetW(InstRetW_n3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_res = '0; m_res3 = '0; m_rd = '0; m_we = 1'b0; m_val = 1'b0; m_cnt = '0;
  endtask

  task automatic check_all();
    chk("result", {32'b0, ResultW}, {32'b0, m_res});
    chk("rd", {59'b0, RdW}, {59'b0, m_rd});
    chk("regwrite", {63'b0, RegWriteW}, {63'b0, m_we});
    chk("valid", {63'b0, ValidW}, {63'b0, m_val});
    chk("instret", {32'b0, InstRetW}, {32'b0, m_cnt});
    chk("c4_result", {32'b0, ResultW_c4}, {32'b0, m_res});
    chk("c4_instret", {60'b0, InstRetW_c4}, {32'b0, m_cnt % 16});
    chk("c4_regwrite", {63'b0, RegWriteW_c4}, {63'b0, m_we});
    chk("n3_result", {32'b0, ResultW_n3}, {32'b0, m_res3});
    chk("n3_rd", {59'b0, RdW_n3}, {59'b0, m_rd});
    chk("n3_valid", {63'b0, ValidW_n3}, {63'b0, m_val});
    chk("n3_instret", {32'b0, InstRetW_n3}, {32'b0, m_cnt});
  endtask

  // One clock: drive M side, take the edge, advance the model, compare.
  task automatic step(input logic stall, input logic flush, input logic valid, input logic rw,
                      input logic [4:0] rd, input logic [1:0] sel);
    StallW = stall; FlushW = flush; ValidM = valid; RegWriteM = rw; RdM = rd; ResultSrcM = sel;
    SrcDataM = {srcs[3], srcs[2], srcs[1], srcs[0]};
    @(posedge clk);
    #1;
    if (flush) begin
      m_res = '0; m_res3 = '0; m_rd = '0; m_we = 1'b0; m_val = 1'b0;
    end else if (!stall) begin
      m_res  = srcs[sel];
      m_res3 = (sel < 3) ? srcs[sel] : 32'h0;
      m_rd   = rd;
      m_we   = rw && valid && (rd != 0);
      m_val  = valid;
      if (valid) m_cnt = m_cnt + 1;
    end
    check_all();
  endtask

  task automatic rand_srcs();
    for (int i = 0; i < 4; i++) srcs[i] = $urandom;
  endtask

  initial begin
    logic [3:0] c4_before;
    reset = 1'b1;
    rand_srcs();
    StallW = $urandom; FlushW = $urandom; ValidM = 1'b1; RegWriteM = 1'b1;
    RdM = 5'($urandom); ResultSrcM = 2'($urandom);
    SrcDataM = {srcs[3], srcs[2], srcs[1], srcs[0]};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    srcs[0] = 32'h0000_1234;
    step(0, 0, 1, 1, 5'd5, 2'd0);
    chk("first_result", {32'b0, ResultW}, 64'h1234);
    chk("first_rd", {59'b0, RdW}, 64'd5);
    chk("first_we", {63'b0, RegWriteW}, 64'd1);
    chk("first_instret", {32'b0, InstRetW}, 64'd1);

    srcs[0] = 32'hA; srcs[1] = 32'hB; srcs[2] = 32'hFFFF_FFF0; srcs[3] = 32'hC;
    for (int s = 0; s < 4; s++) step(0, 0, 1, 1, 5'd3, 2'(s));
    chk("n3_oob_sel", {32'b0, ResultW_n3}, 64'h0);
    step(0, 0, 1, 1, 5'd3, 2'd2);
    chk("pc4_full_width", {32'b0, ResultW}, 64'hFFFF_FFF0);

    step(0, 0, 1, 1, 5'd0, 2'd0);
    chk("x0_no_write", {63'b0, RegWriteW}, 64'd0);
    step(0, 0, 0, 1, 5'd9, 2'd1);
    chk("bubble_valid", {63'b0, ValidW}, 64'd0);

    srcs[0] = 32'h55;
    step(0, 0, 1, 1, 5'd7, 2'd0);
    for (int i = 0; i < 3; i++) begin
      rand_srcs();
      step(1, 0, 1, 1, 5'(i + 10), 2'($urandom));
      chk("stall_hold_result", {32'b0, ResultW}, 64'h55);
      chk("stall_hold_rd", {59'b0, RdW}, 64'd7);
    end
    step(1, 1, 1, 1, 5'd12, 2'd1);
    chk("flush_valid", {63'b0, ValidW}, 64'd0);

    c4_before = InstRetW_c4;
    for (int i = 0; i < 17; i++) begin
      rand_srcs();
      step(0, 0, 1, $urandom, 5'($urandom), 2'($urandom));
    end
    chk("c4_wrap", {60'b0, InstRetW_c4}, {60'b0, 4'(c4_before + 4'd1)});

    for (int i = 0; i < 300; i++) begin
      rand_srcs();
      step(($urandom % 5) == 0, ($urandom % 9) == 0, ($urandom % 4) != 0, $urandom,
           5'($urandom), 2'($urandom));
    end

    srcs[1] = 32'hDEAD_BEEF;
    step(0, 0, 1, 1, 5'd4, 2'd1);
    chk("pre_reset_valid", {63'b0, ValidW}, 64'd1);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 reset = 1'b0;
    srcs[3] = 32'h0BAD_F00D;
    step(0, 0, 1, 1, 5'd8, 2'd3);
    chk("post_reset_instret", {32'b0, InstRetW}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_result_stage.md
# wb_result_stage

Parametrised writeback stage for the pipelined processor: registers the MEM/WB boundary and selects the writeback result from NSRC full-width sources in one block. It replaces the fixed 4:1 result multiplexer: arbitrary data width, a configurable source count, full-width PC+4 with no truncation, stall/flush control, x0 write suppression and a retired-instruction counter. Its outputs drive the register file write port and the hazard unit's W-stage forwarding path.

## Interface
- WIDTH, 32, data width of every source and of the result
- NSRC, 4, number of result sources (2..8)
- SELW, 2, select width; must satisfy 2^SELW >= NSRC
- CNTW, 32, retired-instruction counter width
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- StallW  input  1  hold W-stage registers
- FlushW  input  1  load a bubble into W stage
- ValidM  input  1  M-stage slot holds a real instruction
- RegWriteM  input  1  instruction writes the register file
- RdM  input  5  destination register
- ResultSrcM  input  SELW  source select
- SrcDataM  input  NSRC*WIDTH  source k at bits [k*WIDTH +: WIDTH]; convention: 0 ALUResult, 1 ReadData, 2 PCPlus4, 3 ImmExt
- ResultW  output  WIDTH  selected, registered result
- RdW  output  5  registered destination
- RegWriteW  output  1  qualified register-file write enable
- ValidW  output  1  W stage holds a real instruction
- InstRetW  output  CNTW  count of instructions that entered W

## Operation
- Select (combinational, M side): Sel = SrcDataM[ResultSrcM*WIDTH +: WIDTH] when ResultSrcM < NSRC; otherwise all zeros.
- Qualified write: WeNext = RegWriteM & ValidM & (RdM != 0).
- Per rising edge, priority reset > FlushW > StallW > load:
  - FlushW=1: ValidW<=0, RegWriteW<=0, RdW<=0, ResultW<=0; InstRetW unchanged.
  - FlushW=0, StallW=1: all registers, including InstRetW, hold.
  - Otherwise load: ResultW<=Sel, RdW<=RdM, RegWriteW<=WeNext, ValidW<=ValidM; InstRetW<=InstRetW+1 if ValidM=1.
- FlushW and StallW both asserted: the flush wins, and the bubble is loaded.
- ValidM=0 on load: ValidW=0 and RegWriteW=0. ResultW and RdW still take the input values; they are don't-care for consumers.
- RdM=0 with RegWriteM=1: the instruction retires (ValidW=1, counted), but RegWriteW=0.
- InstRetW wraps modulo 2^CNTW. There is no saturation.
- Width rules: all sources are exactly WIDTH bits and there is no internal extension. PCPlus4 must be supplied at full width by the fetch path.

## Timing
- Reset values (asynchronous, effective while reset=1): ResultW=0, RdW=0, RegWriteW=0, ValidW=0, InstRetW=0.
- Latency: one cycle from M inputs to W outputs. All outputs are registered, with no combinational input-to-output path.
- Reset asserted mid-operation: outputs clear without waiting for clk. The first load occurs on the first rising edge after reset deasserts.
- Stall is level-sensitive. An N-cycle stall holds outputs for N cycles, then loads the M inputs present on the first unstalled edge.
- The register file consumes RegWriteW/RdW/ResultW in the same cycle; the forwarding path reads the same signals.

## Test plan
- Reset: hold reset=1 with random inputs, toggle clk 3 times -> all outputs 0. Deassert reset, then load ValidM=1, RegWriteM=1, RdM=5, ResultSrcM=0, ALU=0x0000_1234 -> next cycle ResultW=0x1234, RdW=5, RegWriteW=1, InstRetW=1.
- Source sweep, with sources 0xA,0xB,0xFFFF_FFF0,0xC: ResultSrcM=0..3 on consecutive cycles -> ResultW 0xA,0xB,0xFFFF_FFF0,0xC one cycle later each. This proves PC+4 is full width.
- x0 and bubble: RdM=0 with RegWriteM=1 -> RegWriteW=0, ValidW=1, counter +1. ValidM=0 -> RegWriteW=0, ValidW=0, counter unchanged.
- Stall/flush: load 0x55 to RdW=7, then StallW=1 for 3 cycles with new inputs -> outputs stay 0x55/7. Then FlushW=StallW=1 -> ValidW=0, RegWriteW=0, ResultW=0, RdW=0.
- Counter wrap: CNTW=4, 17 consecutive valid loads -> InstRetW=1 after the 17th.
- Async reset mid-stream: assert reset between edges while ValidW=1 -> outputs 0 before the next edge. NSRC=3 build with ResultSrcM=3 -> ResultW=0.
